// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter, LSB first, single clock.
// Ports:
//   sys_clk_i  rising-edge clock
//   sys_rst_i  synchronous active-high reset
//   data_i     byte to send
//   valid_i    data_i is valid
//   ready_o    FIFO can accept a byte
//   txd_o      serial line, idles high
//   busy_o     frame in flight or FIFO non-empty
//   level_o    FIFO occupancy, 0..FIFO_DEPTH
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          sys_clk_i,
    input  logic                          sys_rst_i,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          txd_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] FULL   = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          state, state_n;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   count;
    logic [TW-1:0]   timer, timer_n;
    logic [2:0]      idx, idx_n;
    logic [7:0]      shift, shift_n;
    logic            txd, txd_n;
    logic            push, pop, has_data, t_wrap;

    // ready comes only from the registered count, so a same-cycle
    // pop never opens a slot in a full FIFO
    assign ready_o  = (count != FULL);
    assign push     = valid_i && ready_o;
    assign has_data = (count != '0);
    assign t_wrap   = (timer == T_LAST);

    assign txd_o   = txd;
    assign busy_o  = (state != IDLE) || has_data;
    assign level_o = count;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (push) mem[wr_ptr] <= data_i;
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        idx_n   = idx;
        shift_n = shift;
        txd_n   = txd;
        pop     = 1'b0;
        unique case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (has_data) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    timer_n = '0;
                    txd_n   = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (t_wrap) begin
                    timer_n = '0;
                    idx_n   = '0;
                    txd_n   = shift[0];
                    state_n = DATA;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            DATA: begin
                if (t_wrap) begin
                    timer_n = '0;
                    if (idx == 3'd7) begin
                        txd_n   = 1'b1;
                        state_n = STOP;
                    end else begin
                        // next bit is shift[1], which becomes shift[0]
                        shift_n = shift >> 1;
                        idx_n   = idx + 1'b1;
                        txd_n   = shift[1];
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            STOP: begin
                if (t_wrap) begin
                    timer_n = '0;
                    // chain straight into the next start bit
                    if (has_data) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        txd_n   = 1'b0;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state <= IDLE;
            timer <= '0;
            idx   <= '0;
            shift <= '0;
            txd   <= 1'b1;
        end else begin
            state <= state_n;
            timer <= timer_n;
            idx   <= idx_n;
            shift <= shift_n;
            txd   <= txd_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo
// with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       txd;
    logic       busy;
    logic [2:0] level;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int frame_err = 0;

    logic [7:0] rx_q [$];
    int         st_q [$];

    logic       dec_on = 1'b0;
    int         dec_cnt = 0;
    logic [7:0] dec_sr = '0;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .sys_clk_i (clk),
        .sys_rst_i (rst),
        .data_i    (data),
        .valid_i   (valid),
        .ready_o   (ready),
        .txd_o     (txd),
        .busy_o    (busy),
        .level_o   (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Serial decoder: samples mid-bit on the falling edge and records
    // each frame's byte and the cycle its start bit was first seen.
    always @(negedge clk) begin
        if (rst) begin
            dec_on <= 1'b0;
        end else if (!dec_on) begin
            if (txd === 1'b0) begin
                dec_on  <= 1'b1;
                dec_cnt <= 0;
                st_q.push_back(cyc);
            end
        end else begin
            dec_cnt <= dec_cnt + 1;
            if ((dec_cnt + 1) % CPB == CPB / 2) begin
                if ((dec_cnt + 1) / CPB >= 1 && (dec_cnt + 1) / CPB <= 8)
                    dec_sr[(dec_cnt + 1) / CPB - 1] <= txd;
                if ((dec_cnt + 1) / CPB == 9) begin
                    rx_q.push_back(dec_sr);
                    if (txd !== 1'b1) frame_err <= frame_err + 1;
                end
            end
            if (dec_cnt + 1 == 10 * CPB - 1) dec_on <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on the first cycle of the start bit; checks every cycle
    // of all ten bits and leaves time just after the stop bit.
    task automatic check_frame(input logic [7:0] b, input string tag);
        logic [9:0]     bits;
        logic [CPB-1:0] s;
        bits = {1'b1, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < CPB; c++) begin
                s[c] = txd;
                tick();
            end
            chk($sformatf("%s bit%0d", tag, j), 64'(s), 64'({CPB{bits[j]}}));
        end
    endtask

    task automatic wait_idle(input string tag, input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        chk($sformatf("%s idle in time", tag), 64'(n < bound), 64'd1);
    endtask

    initial begin
        int n;
        int i;
        int lows;
        logic acc;

        rst   = 1'b1;
        data  = '0;
        valid = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset txd", 64'(txd), 64'd1);
        chk("reset ready", 64'(ready), 64'd1);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset level", 64'(level), 64'd0);

        // single byte: push, one-edge pop latency, exact bit timing
        data  = 8'hA5;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("a5 level after push", 64'(level), 64'd1);
        chk("a5 txd before pop", 64'(txd), 64'd1);
        chk("a5 busy", 64'(busy), 64'd1);
        tick();
        chk("a5 txd start", 64'(txd), 64'd0);
        chk("a5 level after pop", 64'(level), 64'd0);
        check_frame(8'hA5, "a5");
        chk("a5 busy after stop", 64'(busy), 64'd0);
        chk("a5 txd idle", 64'(txd), 64'd1);
        tick();
        rx_q.delete();
        st_q.delete();

        // burst to full, then hold valid through the full period
        for (int k = 0; k < 5; k++) begin
            data  = 8'h10 + 8'(k);
            valid = 1'b1;
            tick();
        end
        data = 8'h15;
        chk("burst level full", 64'(level), 64'd4);
        chk("burst ready low", 64'(ready), 64'd0);
        n = 0;
        while (level == 3'd4 && n < 200) begin
            tick();
            n++;
        end
        chk("full ignored cycles", 64'(n), 64'd37);
        chk("full pop no push", 64'(level), 64'd3);
        chk("ready after pop", 64'(ready), 64'd1);
        tick();
        valid = 1'b0;
        chk("push after pop", 64'(level), 64'd4);
        wait_idle("burst", 600);
        repeat (20) tick();
        chk("burst frames", 64'(rx_q.size()), 64'd6);
        for (int k = 0; k < rx_q.size() && k < 6; k++)
            chk($sformatf("burst byte%0d", k), 64'(rx_q[k]),
                64'(8'h10 + 8'(k)));
        for (int k = 0; k + 1 < st_q.size() && k < 5; k++)
            chk($sformatf("burst pitch%0d", k),
                64'(st_q[k+1] - st_q[k]), 64'(10 * CPB));
        rx_q.delete();
        st_q.delete();

        // pointer wrap: 3 x depth bytes with random valid gaps
        i = 0;
        n = 0;
        while (i < 3 * DEPTH && n < 5000) begin
            valid = 1'($urandom_range(0, 1));
            data  = 8'(i);
            acc   = valid && ready;
            tick();
            if (acc) i++;
            n++;
        end
        valid = 1'b0;
        chk("wrap push in time", 64'(n < 5000), 64'd1);
        wait_idle("wrap", 1500);
        repeat (20) tick();
        chk("wrap frames", 64'(rx_q.size()), 64'(3 * DEPTH));
        for (int k = 0; k < rx_q.size() && k < 3 * DEPTH; k++)
            chk($sformatf("wrap byte%0d", k), 64'(rx_q[k]), 64'(k));
        rx_q.delete();
        st_q.delete();

        // reset during data bit 3 with two bytes queued
        data  = 8'h35;
        valid = 1'b1;
        tick();
        data = 8'h5A;
        tick();
        data = 8'h77;
        tick();
        valid = 1'b0;
        chk("rst queued", 64'(level), 64'd2);
        repeat (16) tick();
        chk("rst pre bit3", 64'(txd), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst txd", 64'(txd), 64'd1);
        chk("rst level", 64'(level), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst ready", 64'(ready), 64'd1);
        rx_q.delete();
        st_q.delete();
        lows = 0;
        repeat (100) begin
            if (txd !== 1'b1) lows++;
            tick();
        end
        chk("rst no tx", 64'(lows), 64'd0);
        chk("rst no start", 64'(st_q.size()), 64'd0);

        // recovery after reset
        data  = 8'hC3;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        chk("c3 level", 64'(level), 64'd1);
        tick();
        chk("c3 txd start", 64'(txd), 64'd0);
        check_frame(8'hC3, "c3");
        chk("c3 busy after", 64'(busy), 64'd0);
        repeat (4) tick();
        chk("stop bits", 64'(frame_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
